// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential Booth multiplier family.
// State encoding, Booth pair codes and the step-counter width helper.
package mult_pkg;

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t CALC = 1'b1;

  // {B[0], q} pair codes; 2'b11 behaves as BOOTH_NOP.
  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/seq_multiplier_n_booth_step.sv
// One radix-2 Booth step: conditional add/subtract of A into P_hi, then arithmetic shift right.
// Purely combinational; no backpressure.
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0] p_hi,
  input  logic [WIDTH:0] a_ext,
  input  logic [1:0]     pair,
  input  logic [WIDTH:0] b_reg,
  output logic [WIDTH:0] p_hi_nxt,
  output logic [WIDTH:0] b_nxt,
  output logic           q_nxt
);

  logic [WIDTH+1:0] p_w;
  logic [WIDTH+1:0] a_w;
  logic [WIDTH+1:0] sum;

  // One extra guard bit keeps the intermediate sign correct before the shift.
  assign p_w = {p_hi[WIDTH], p_hi};
  assign a_w = {a_ext[WIDTH], a_ext};

  always_comb begin
    sum = p_w;
    case (pair)
      BOOTH_ADD: sum = p_w + a_w;
      BOOTH_SUB: sum = p_w - a_w;
      default:   sum = p_w;
    endcase
  end

  assign p_hi_nxt = sum[WIDTH+1:1];
  assign b_nxt    = {sum[0], b_reg[WIDTH:1]};
  assign q_nxt    = b_reg[0];

endmodule

// File: rtl/seq_multiplier_n.sv
// Parametrised signed/unsigned sequential multiplier, radix-2 Booth, one step per cycle.
// Latency WIDTH+1 cycles; start is ignored while busy, result held until the next completion.
module seq_multiplier_n
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic [2*WIDTH-1:0]   out,
  output logic                 flag,
  output logic                 busy
);

  localparam int CW = cnt_width(WIDTH);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [WIDTH:0] p_hi;
  logic [WIDTH:0] a_reg;
  logic [WIDTH:0] b_reg;
  logic           q;

  logic [WIDTH:0] p_nxt;
  logic [WIDTH:0] b_nxt;
  logic           q_nxt;

  logic [WIDTH:0] a_in;
  logic [WIDTH:0] b_in;

  assign a_in = {signed_mode & a[WIDTH-1], a};
  assign b_in = {signed_mode & b[WIDTH-1], b};

  booth_step #(.WIDTH(WIDTH)) u_step (
    .p_hi     (p_hi),
    .a_ext    (a_reg),
    .pair     ({b_reg[0], q}),
    .b_reg    (b_reg),
    .p_hi_nxt (p_nxt),
    .b_nxt    (b_nxt),
    .q_nxt    (q_nxt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      p_hi  <= '0;
      a_reg <= '0;
      b_reg <= '0;
      q     <= 1'b0;
      out   <= '0;
      flag  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      flag <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a_in;
            b_reg <= b_in;
            p_hi  <= '0;
            q     <= 1'b0;
            cnt   <= '0;
            state <= CALC;
            busy  <= 1'b1;
          end
        end
        CALC: begin
          p_hi <= p_nxt;
          b_reg <= b_nxt;
          q     <= q_nxt;
          cnt   <= cnt + 1'b1;
          // Step index WIDTH is the (WIDTH+1)th and final step.
          if (cnt == CW'(WIDTH)) begin
            out   <= {p_nxt[WIDTH-2:0], b_nxt};
            flag  <= 1'b1;
            busy  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier_n.sv
// Randomised and directed bench for seq_multiplier_n at WIDTH=8 and WIDTH=16.
module tb_seq_multiplier_n;

  logic clk;
  logic rst;

  logic        start8, sm8, flag8, busy8;
  logic [7:0]  a8, b8;
  logic [15:0] out8;

  logic        start16, sm16, flag16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] out16;

  int n_vec = 0;
  int n_err = 0;

  bit          sel;
  logic [31:0] cur_out;
  logic        cur_flag, cur_busy;
  assign cur_out  = sel ? out16 : {16'b0, out8};
  assign cur_flag = sel ? flag16 : flag8;
  assign cur_busy = sel ? busy16 : busy8;

  seq_multiplier_n #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .signed_mode(sm8),
    .out(out8), .flag(flag8), .busy(busy8)
  );

  seq_multiplier_n #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .a(a16), .b(b16), .signed_mode(sm16),
    .out(out16), .flag(flag16), .busy(busy16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Exact product of two w-bit operands, reduced to 2w bits.
  function automatic logic [63:0] ref_mul(input int w, input logic [15:0] av,
                                          input logic [15:0] bv, input bit sm);
    longint sa, sb, p, mask;
    mask = (longint'(1) <<< w) - 1;
    sa = longint'(av) & mask;
    sb = longint'(bv) & mask;
    if (sm && av[w-1]) sa = sa - (longint'(1) <<< w);
    if (sm && bv[w-1]) sb = sb - (longint'(1) <<< w);
    p = sa * sb;
    return 64'(p & ((longint'(1) <<< (2*w)) - 1));
  endfunction

  task automatic drive(input int w, input logic st, input logic [15:0] av,
                       input logic [15:0] bv, input bit sm);
    if (w == 8) begin
      start8 = st; a8 = av[7:0]; b8 = bv[7:0]; sm8 = sm;
    end else begin
      start16 = st; a16 = av; b16 = bv; sm16 = sm;
    end
  endtask

  task automatic run_op(input int w, input logic [15:0] av, input logic [15:0] bv,
                        input bit sm, input string tag);
    int n, nb;
    logic [31:0] r;
    sel = (w == 16);
    @(negedge clk);
    drive(w, 1'b1, av, bv, sm);
    @(posedge clk); #1;
    check({tag, "_busy0"}, 64'(cur_busy), 64'd1);
    r = $urandom;
    // operands wander during CALC and must not matter
    drive(w, 1'b0, r[15:0], r[31:16], r[0]);
    n = 0; nb = 1;
    while (!cur_flag && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (cur_busy) nb++;
    end
    check({tag, "_lat"}, 64'(n), 64'(w + 1));
    check({tag, "_prod"}, 64'(cur_out), ref_mul(w, av, bv, sm));
    check({tag, "_busycyc"}, 64'(nb), 64'(w + 1));
    @(posedge clk); #1;
    check({tag, "_flagfall"}, 64'(cur_flag), 64'd0);
  endtask

  initial begin
    int n, nf;
    logic [31:0] ra, rb;
    drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
    drive(16, 1'b0, 16'd0, 16'd0, 1'b0);
    sel = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out8", 64'(out8), 64'd0);
    check("rst_flag8", 64'(flag8), 64'd0);
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_out16", 64'(out16), 64'd0);
    @(negedge clk) rst = 1'b1;

    run_op(8, 16'd5, 16'd10, 1'b0, "u5x10");
    run_op(8, 16'd7, 16'd4, 1'b0, "u7x4");
    run_op(8, 16'hFF, 16'hFF, 1'b0, "u255x255");
    run_op(8, 16'hFD, 16'd5, 1'b1, "sm3x5");
    run_op(8, 16'h80, 16'h80, 1'b1, "s80x80");
    run_op(8, 16'h80, 16'h7F, 1'b1, "s80x7f");
    run_op(8, 16'hFF, 16'hFF, 1'b1, "sffxff");
    run_op(8, 16'h00, 16'hFF, 1'b1, "s0xff");
    run_op(16, 16'hFFFF, 16'hFFFF, 1'b0, "u16max");
    run_op(16, 16'h8000, 16'h8000, 1'b1, "s16min");

    // start during CALC ignored; start held into the flag cycle is accepted
    sel = 1'b0;
    @(negedge clk);
    drive(8, 1'b1, 16'd12, 16'd11, 1'b0);
    @(posedge clk); #1;
    drive(8, 1'b0, 16'd12, 16'd11, 1'b0);
    n = 0;
    while (!flag8 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (n == 2) drive(8, 1'b1, 16'hF6, 16'd9, 1'b1);
    end
    check("ign_lat", 64'(n), 64'd9);
    check("ign_prod", 64'(out8), ref_mul(8, 16'd12, 16'd11, 1'b0));
    n = 0;
    @(posedge clk); #1;
    n++;
    check("b2b_busy", 64'(busy8), 64'd1);
    drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
    while (!flag8 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("b2b_gap", 64'(n), 64'd10);
    check("b2b_prod", 64'(out8), ref_mul(8, 16'hF6, 16'd9, 1'b1));

    // reset in the middle of an operation
    @(negedge clk);
    drive(8, 1'b1, 16'd200, 16'd3, 1'b0);
    @(posedge clk); #1;
    drive(8, 1'b0, 16'd0, 16'd0, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_out", 64'(out8), 64'd0);
    check("mid_rst_flag", 64'(flag8), 64'd0);
    check("mid_rst_busy", 64'(busy8), 64'd0);
    @(negedge clk); @(negedge clk) rst = 1'b1;
    nf = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (flag8) nf++;
    end
    check("mid_rst_noflag", 64'(nf), 64'd0);
    run_op(8, 16'd9, 16'd9, 1'b0, "post_rst");

    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom;
      run_op(8, ra[15:0], rb[15:0], ra[31], "rnd8");
    end
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom;
      run_op(16, ra[15:0], rb[15:0], rb[31], "rnd16");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_multiplier_n.md
# seq_multiplier_n

Parametrised sequential multiplier: the next generation of the team's 8-bit shift-add multiplier. Operand width is a parameter, and the block adds a per-operation signed/unsigned mode using radix-2 Booth recoding. It also adds an explicit busy output, so a controller can issue operations back to back. It sits beside the existing arithmetic blocks and uses the same start/out/flag handshake style.

## Interface
- WIDTH, 8, operand width in bits (≥2); product width is 2*WIDTH
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only while busy=0
- a  in  WIDTH  multiplicand, captured when start is accepted
- b  in  WIDTH  multiplier, captured when start is accepted
- signed_mode  in  1  1 = two's-complement operands, 0 = unsigned; captured with the operands
- out  out  2*WIDTH  product; holds the last result until the next completion
- flag  out  1  one-cycle pulse marking the cycle in which out first shows a new result
- busy  out  1  high while an operation is in progress

## Operation
- Two states: IDLE and CALC.
- **Accept (IDLE, start=1 at a rising edge):**
  - Form A and B as WIDTH+1-bit values: sign-extended if signed_mode=1, zero-extended if 0.
  - Load the accumulator/multiplier register {P_hi (WIDTH+1 bits), B, q=0} with P_hi=0.
  - Step counter = 0; enter CALC; busy becomes 1.
- **CALC, each cycle (one Booth step):**
  - Examine {B[0], q}: 01 → P_hi += A; 10 → P_hi −= A; 00/11 → no add.
  - Arithmetic-shift the full register right by one, with sign taken from the updated P_hi MSB.
  - Increment the counter.
- **Completion:**
  - After WIDTH+1 steps, write the low 2*WIDTH bits of {P_hi,B} to out.
  - Assert flag for that cycle; go to IDLE; busy becomes 0.
- **Arithmetic:** P_hi add/subtract is computed at WIDTH+2 bits so no overflow is lost. The result is exact for all operand pairs in both modes. Unsigned results are modulo-free because the product fits in 2*WIDTH bits.
- **Boundary conditions:**
  - start while busy=1: ignored; operands are not re-captured.
  - start held high continuously: a new operation is accepted at every IDLE edge.
  - a, b and signed_mode may change freely during CALC with no effect.
  - Operand 0 or WIDTH'1 in either mode: no special case; same latency.
- **Reset:** asserting rst at any time, including mid-CALC, immediately sets IDLE, out=0, flag=0, busy=0, counter=0. The aborted operation produces no flag.

## Timing
- Reset values: out=0, flag=0, busy=0.
- Let edge T0 be the edge at which start is accepted:
  - busy=1 from T0 until T(WIDTH+1).
  - CALC steps occur at edges T1…T(WIDTH+1).
  - out updates and flag=1 after edge T(WIDTH+1); flag falls at T(WIDTH+2).
  - Latency is WIDTH+1 cycles (9 for WIDTH=8), independent of operand values and mode.
- busy=0 during the flag cycle, so start=1 in that cycle is accepted at T(WIDTH+2). Back-to-back throughput is one result per WIDTH+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package mult_pkg holds:
  - the state typedef (IDLE, CALC);
  - the Booth pair encodings (BOOTH_NOP, BOOTH_ADD, BOOTH_SUB);
  - the helper constant for counter width, $clog2(WIDTH+2).
- One combinational sub-module, booth_step: inputs P_hi, A, the Booth pair and the B/q bits; outputs the next shifted register. The top level holds the FSM, counter and registers.

## Test plan
- WIDTH=8, unsigned, a=5, b=10, start one cycle → out=16'd50, flag high exactly 9 cycles after the accept edge, busy high for 9 cycles. Then a=7, b=4 → out=16'd28.
- Unsigned a=255, b=255 → out=16'hFE01. Signed a=8'hFD (−3), b=5 → out=16'hFFF1 (−15).
- Signed a=8'h80, b=8'h80 (−128×−128) → out=16'h4000. Signed a=8'h80, b=8'h7F → out=16'hC080 (−16256).
- Start at T0, then start=1 with new a/b/mode at T3 → request ignored; out equals the first product at T9. start=1 in the flag cycle → second result 10 cycles after the first.
- Pull rst low at T4 of an operation → out=0, flag=0, busy=0 immediately and no flag follows. A fresh start after release completes normally.
- Randomised pairs at WIDTH=8 and WIDTH=16, both modes, against a reference model → every product exact and latency constant at WIDTH+1.
